i2s_receiver: RTL

//  Serial-to-parallel I2S receiver; the receive-side counterpart of the I2S transmit controller.

---
 rtl/i2s_receiver.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/i2s_receiver.sv
// I2S receiver: brings SCLK/LRCK/SDOUT from an external codec into the system
// clock domain, recovers one MSB-first PCM word per LRCK half and hands the
// words out on a valid/ready stream together with a channel tag.
// Sticky status flags record dropped words (overrun) and short slots (frame_err).
//
// Handshake: a word is transferred in every clk cycle where out_valid and
// out_ready are both 1. While out_valid is 1 and out_ready is 0, out_data and
// out_right hold their values. out_valid does not depend on out_ready within
// the same cycle.

module i2s_receiver #(
  parameter int BIT_DEPTH = 24,
  parameter int SLOT_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i2s_sclk,
  input  logic                 i2s_lrck,
  input  logic                 i2s_sdout,
  output logic [BIT_DEPTH-1:0] out_data,
  output logic                 out_right,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 clear_status,
  output logic                 overrun,
  output logic                 frame_err
);

  // The bit counter only has to reach BIT_DEPTH, which never exceeds one slot.
  localparam int CNT_W = (SLOT_BITS > 2) ? $clog2(SLOT_BITS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SKIP  = 2'd1,
    SHIFT = 2'd2,
    WAIT  = 2'd3
  } state_t;

  // Synchroniser chains: identical depth on all three inputs so that the
  // sampled lrck/sdout belong to the same SCLK rising edge as sclk_rise.
  logic sclk_meta, sclk_sync, sclk_d;
  logic lrck_meta, lrck_sync;
  logic sdout_meta, sdout_sync;

  // Receiver state; state is kept as a named signal for checker binding.
  state_t               state;
  logic                 chan;
  logic                 lrck_prev;
  logic                 primed;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_DEPTH-1:0] shift;

  logic                 sclk_rise;
  logic                 lrck_edge;
  logic [BIT_DEPTH-1:0] shift_next;
  logic                 word_done;
  logic                 load_ok;

  // Two-flop synchronisers plus one extra sclk stage for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_meta  <= 1'b0;
      sclk_sync  <= 1'b0;
      sclk_d     <= 1'b0;
      lrck_meta  <= 1'b0;
      lrck_sync  <= 1'b0;
      sdout_meta <= 1'b0;
      sdout_sync <= 1'b0;
    end else begin
      sclk_meta  <= i2s_sclk;
      sclk_sync  <= sclk_meta;
      sclk_d     <= sclk_sync;
      lrck_meta  <= i2s_lrck;
      lrck_sync  <= lrck_meta;
      sdout_meta <= i2s_sdout;
      sdout_sync <= sdout_meta;
    end
  end

  // Event decode for the current clk cycle.
  always_comb begin
    sclk_rise  = sclk_sync & ~sclk_d;
    lrck_edge  = (lrck_sync != lrck_prev);
    shift_next = (shift << 1) | BIT_DEPTH'(sdout_sync);
    word_done  = sclk_rise && (state == SHIFT) && !lrck_edge &&
                 (cnt == CNT_W'(BIT_DEPTH - 1));
    load_ok    = !out_valid || out_ready;
  end

  // Slot FSM, output register and sticky status in one registered process.
  // Later assignments in this block take priority: a new word overrides the
  // acceptance clear of out_valid, and a status set overrides clear_status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      chan      <= 1'b0;
      lrck_prev <= 1'b0;
      primed    <= 1'b0;
      cnt       <= '0;
      shift     <= '0;
      out_data  <= '0;
      out_right <= 1'b0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (clear_status) begin
        overrun   <= 1'b0;
        frame_err <= 1'b0;
      end

      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (sclk_rise) begin
        lrck_prev <= lrck_sync;

        case (state)
          IDLE: begin
            // The first bit after reset only establishes lrck_prev, so the
            // slot that was in progress at reset is skipped silently.
            if (!primed) begin
              primed <= 1'b1;
            end else if (lrck_edge) begin
              chan  <= lrck_sync;
              state <= SKIP;
            end
          end

          SKIP: begin
            if (lrck_edge) begin
              // A slot with no data bits at all is malformed.
              frame_err <= 1'b1;
              chan      <= lrck_sync;
            end else begin
              shift <= shift_next;
              cnt   <= CNT_W'(1);
              state <= SHIFT;
            end
          end

          SHIFT: begin
            if (lrck_edge) begin
              // Short slot: drop the partial word; this edge is the new
              // channel's delay bit.
              frame_err <= 1'b1;
              chan      <= lrck_sync;
              cnt       <= '0;
              state     <= SKIP;
            end else begin
              shift <= shift_next;
              cnt   <= cnt + CNT_W'(1);
              if (word_done) begin
                state <= WAIT;
              end
            end
          end

          WAIT: begin
            // Padding bits up to the end of the slot are ignored.
            if (lrck_edge) begin
              chan  <= lrck_sync;
              cnt   <= '0;
              state <= SKIP;
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end

      if (word_done) begin
        if (load_ok) begin
          out_data  <= shift_next;
          out_right <= chan;
          out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule
